frame_packer: RTL and testbench

- Sits directly downstream of the concatenator stage.
- Accepts its registered valid-only word stream, which has no backpressure, and groups it into fixed frames of NUM_WORDS words.
- Buffers the frames in a packet FIFO and emits them on a ready/valid stream with first/last markers.
- Only whole frames are ever emitted: on overflow the partial frame is rolled back and the remainder of that input frame is discarded.

---
 rtl/frame_packer_if.sv | 36 +++
 rtl/frame_packer.sv | 157 +++++++++++++++
 tb/tb_frame_packer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_packer_if.sv
// Bus bundle for frame_packer: valid-only input word stream plus a
// ready/valid output frame stream with first/last markers and drop status.
//
// Handshake: the input side has no ready, so every cycle with i_in_valid=1
// presents one word that is either stored or dropped. On the output side a
// word transfers on a rising clock edge where o_out_valid && i_out_ready;
// while o_out_valid && !i_out_ready, o_out_data/o_out_first/o_out_last hold
// their values, and o_out_valid never drops without a transfer.
interface frame_packer_if #(
  parameter int WIDTH      = 8,
  parameter int DROP_CNT_W = 16
);
  logic [WIDTH-1:0]      i_in_data;
  logic                  i_in_valid;
  logic [WIDTH-1:0]      o_out_data;
  logic                  o_out_valid;
  logic                  i_out_ready;
  logic                  o_out_first;
  logic                  o_out_last;
  logic                  o_overflow;
  logic [DROP_CNT_W-1:0] o_frames_dropped;

  // Driving side (upstream source and downstream sink together).
  modport master (
    output i_in_data, i_in_valid, i_out_ready,
    input  o_out_data, o_out_valid, o_out_first, o_out_last,
           o_overflow, o_frames_dropped
  );

  // The packer itself.
  modport slave (
    input  i_in_data, i_in_valid, i_out_ready,
    output o_out_data, o_out_valid, o_out_first, o_out_last,
           o_overflow, o_frames_dropped
  );
endinterface

// File: rtl/frame_packer.sv
// Groups a backpressure-free word stream into NUM_WORDS-word frames, stores
// them in a packet FIFO and replays only complete frames on a ready/valid
// stream. A frame that cannot fit is rolled back and its remainder discarded.
module frame_packer #(
  parameter int WIDTH      = 8,
  parameter int NUM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 2048,
  parameter int DROP_CNT_W = 16
) (
  input  logic           i_clock,
  input  logic           i_reset,
  frame_packer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(NUM_WORDS);

  if (NUM_WORDS < 2 || FIFO_DEPTH < NUM_WORDS ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $fatal(1, "frame_packer: need NUM_WORDS>=2 and power-of-two FIFO_DEPTH>=NUM_WORDS");
  end

  typedef enum logic {ST_ACCEPT = 1'b0, ST_DISCARD = 1'b1} in_state_e;

  // Input FSM state; readable hierarchically for debug and checkers.
  in_state_e state_q, state_d;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;        // next word to transfer; frees space
  logic [PW-1:0]         fetch_ptr_q, fetch_ptr_d;  // next word to prefetch from memory
  logic [IW-1:0]         in_idx_q, in_idx_d;
  logic [IW-1:0]         out_idx_q, out_idx_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  s1_valid_q, s1_valid_d;    // rd_data_q holds a prefetched word
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [WIDTH-1:0]      rd_data_q;
  logic [WIDTH-1:0]      mem [FIFO_DEPTH];

  logic [PW-1:0] used;
  logic          full;
  logic          last_in;
  logic          last_out;
  logic          wr_en;
  logic          avail;
  logic          xfer;
  logic          s1_adv;
  logic          fetch;

  // Occupancy counts every word not yet handed downstream, so prefetched
  // copies never free space early and a same-cycle read cannot avoid a drop.
  assign used     = wr_ptr_q - rd_ptr_q;
  assign full     = (used == PW'(FIFO_DEPTH));
  assign last_in  = (in_idx_q == IW'(NUM_WORDS - 1));
  assign last_out = (out_idx_q == IW'(NUM_WORDS - 1));

  // Input FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= ST_ACCEPT;
    else         state_q <= state_d;
  end

  // Input FSM next state: an overflow mid-frame discards the frame's rest.
  always_comb begin
    state_d = state_q;
    if (bus.i_in_valid) begin
      case (state_q)
        ST_ACCEPT:  if (full && !last_in) state_d = ST_DISCARD;
        ST_DISCARD: if (last_in) state_d = ST_ACCEPT;
        default:    state_d = ST_ACCEPT;
      endcase
    end
  end

  // Input FSM actions: store, commit a finished frame, or roll back on overflow.
  always_comb begin
    wr_en        = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    in_idx_d     = in_idx_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    if (bus.i_in_valid) begin
      in_idx_d = last_in ? '0 : in_idx_q + 1'b1;
      if (state_q == ST_ACCEPT) begin
        if (!full) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (last_in) commit_ptr_d = wr_ptr_q + 1'b1;
        end else begin
          wr_ptr_d   = commit_ptr_q;
          overflow_d = 1'b1;
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        end
      end
    end
  end

  // Output pipeline: memory read register feeding a single output register.
  // A new fetch is issued whenever the read register will be free next cycle.
  always_comb begin
    avail       = (fetch_ptr_q != commit_ptr_q);
    xfer        = out_valid_q && bus.i_out_ready;
    s1_adv      = s1_valid_q && (!out_valid_q || bus.i_out_ready);
    fetch       = avail && (!s1_valid_q || s1_adv);
    fetch_ptr_d = fetch ? fetch_ptr_q + 1'b1 : fetch_ptr_q;
    rd_ptr_d    = xfer ? rd_ptr_q + 1'b1 : rd_ptr_q;
    s1_valid_d  = fetch ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    out_valid_d = s1_adv ? 1'b1 : (xfer ? 1'b0 : out_valid_q);
    out_data_d  = s1_adv ? rd_data_q : out_data_q;
    out_idx_d   = xfer ? (last_out ? '0 : out_idx_q + 1'b1) : out_idx_q;
  end

  // Buffer storage with a registered read port; contents are not reset.
  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= bus.i_in_data;
    if (fetch) rd_data_q <= mem[fetch_ptr_q[AW-1:0]];
  end

  // Pointer, counter and output register state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      in_idx_q     <= '0;
      out_idx_q    <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      in_idx_q     <= in_idx_d;
      out_idx_q    <= out_idx_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.o_out_data       = out_data_q;
  assign bus.o_out_valid      = out_valid_q;
  assign bus.o_out_first      = out_valid_q && (out_idx_q == '0);
  assign bus.o_out_last       = out_valid_q && last_out;
  assign bus.o_overflow       = overflow_q;
  assign bus.o_frames_dropped = drop_cnt_q;
endmodule

// File: tb/tb_frame_packer.sv
// Bench for frame_packer: two instances (4-word and 3-word frames, 8-word
// buffer), directed sequences, an overflow vector table and a randomized
// run checked against an expected-word queue per instance.
module tb_frame_packer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 clk = ~clk;

  frame_packer_if #(.WIDTH(W), .DROP_CNT_W(16)) a_if ();
  frame_packer_if #(.WIDTH(W), .DROP_CNT_W(2))  b_if ();

  frame_packer #(.WIDTH(W), .NUM_WORDS(4), .FIFO_DEPTH(8), .DROP_CNT_W(16)) u_a (
    .i_clock(clk), .i_reset(i_reset), .bus(a_if.slave));
  frame_packer #(.WIDTH(W), .NUM_WORDS(3), .FIFO_DEPTH(8), .DROP_CNT_W(2)) u_b (
    .i_clock(clk), .i_reset(i_reset), .bus(b_if.slave));

  int checks = 0;
  int failures = 0;
  int xfer_a = 0;
  bit rand_ready = 1'b0;

  // Expected words: {first, last, data}.
  logic [W+1:0] exp_a_q[$];
  logic [W+1:0] exp_b_q[$];

  typedef struct {
    logic [W-1:0] data;
    logic         exp_ov;
    logic [15:0]  exp_drop;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) a_if.i_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic feed_a(input logic [W-1:0] d);
    a_if.i_in_valid = 1'b1;
    a_if.i_in_data  = d;
    step();
    a_if.i_in_valid = 1'b0;
  endtask

  task automatic feed_b(input logic [W-1:0] d);
    b_if.i_in_valid = 1'b1;
    b_if.i_in_data  = d;
    step();
    b_if.i_in_valid = 1'b0;
  endtask

  task automatic push_frame(input int sel, input logic [W-1:0] base);
    int nw;
    nw = (sel == 0) ? 4 : 3;
    for (int i = 0; i < nw; i++) begin
      if (sel == 0) exp_a_q.push_back({i == 0, i == nw - 1, 8'(base + i)});
      else          exp_b_q.push_back({i == 0, i == nw - 1, 8'(base + i)});
    end
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (n < 200 && ((sel == 0) ? (exp_a_q.size() != 0 || a_if.o_out_valid)
                                  : (exp_b_q.size() != 0 || b_if.o_out_valid))) begin
      step();
      n++;
    end
    if (sel == 0) check("a_drain_words_left", exp_a_q.size(), 0);
    else          check("b_drain_words_left", exp_b_q.size(), 0);
  endtask

  // Scoreboard and hold checker for instance A.
  logic         a_stall = 1'b0;
  logic [W+1:0] a_held;
  always @(negedge clk) begin
    if (i_reset) begin
      a_stall = 1'b0;
    end else begin
      if (a_stall)
        check("a_hold_while_stalled",
              {a_if.o_out_valid, a_if.o_out_first, a_if.o_out_last, a_if.o_out_data},
              {1'b1, a_held});
      if (a_if.o_out_valid && a_if.i_out_ready) begin
        xfer_a++;
        if (exp_a_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_word actual=0x%0h required=none", a_if.o_out_data);
        end else begin
          check("a_word", {a_if.o_out_first, a_if.o_out_last, a_if.o_out_data},
                exp_a_q.pop_front());
        end
      end
      a_stall = a_if.o_out_valid && !a_if.i_out_ready;
      a_held  = {a_if.o_out_first, a_if.o_out_last, a_if.o_out_data};
    end
  end

  // Scoreboard and hold checker for instance B.
  logic         b_stall = 1'b0;
  logic [W+1:0] b_held;
  always @(negedge clk) begin
    if (i_reset) begin
      b_stall = 1'b0;
    end else begin
      if (b_stall)
        check("b_hold_while_stalled",
              {b_if.o_out_valid, b_if.o_out_first, b_if.o_out_last, b_if.o_out_data},
              {1'b1, b_held});
      if (b_if.o_out_valid && b_if.i_out_ready) begin
        if (exp_b_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_word actual=0x%0h required=none", b_if.o_out_data);
        end else begin
          check("b_word", {b_if.o_out_first, b_if.o_out_last, b_if.o_out_data},
                exp_b_q.pop_front());
        end
      end
      b_stall = b_if.o_out_valid && !b_if.i_out_ready;
      b_held  = {b_if.o_out_first, b_if.o_out_last, b_if.o_out_data};
    end
  end

  initial begin
    int n;
    int fed;
    int xa0;
    logic [W-1:0] d;

    // Overflow table for instance A (4-word frames, 8-word buffer, ready low).
    for (int i = 0; i < 16; i++) begin
      tbl[i].data     = 8'(8'h30 + i);
      tbl[i].exp_ov   = (i >= 8);
      tbl[i].exp_drop = (i < 8) ? 16'd0 : ((i < 12) ? 16'd1 : 16'd2);
    end

    a_if.i_in_valid = 1'b0; a_if.i_in_data = '0; a_if.i_out_ready = 1'b0;
    b_if.i_in_valid = 1'b0; b_if.i_in_data = '0; b_if.i_out_ready = 1'b0;

    // Reset held three cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      a_if.i_in_valid = 1'($urandom_range(0, 1)); a_if.i_in_data = 8'($urandom_range(0, 255));
      a_if.i_out_ready = 1'($urandom_range(0, 1));
      b_if.i_in_valid = 1'($urandom_range(0, 1)); b_if.i_in_data = 8'($urandom_range(0, 255));
      b_if.i_out_ready = 1'($urandom_range(0, 1));
      step();
      check("a_reset_outputs", {a_if.o_out_data, a_if.o_out_valid, a_if.o_out_first,
            a_if.o_out_last, a_if.o_overflow, a_if.o_frames_dropped}, 0);
      check("b_reset_outputs", {b_if.o_out_data, b_if.o_out_valid, b_if.o_out_first,
            b_if.o_out_last, b_if.o_overflow, b_if.o_frames_dropped}, 0);
    end
    a_if.i_in_valid = 1'b0; b_if.i_in_valid = 1'b0;
    a_if.i_out_ready = 1'b1; b_if.i_out_ready = 1'b1;
    i_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("a_idle_valid", a_if.o_out_valid, 0);
    end

    // Back-to-back frame and first-word latency.
    push_frame(0, 8'h10);
    for (int i = 0; i < 3; i++) feed_a(8'(8'h10 + i));
    feed_a(8'h13);
    check("lat_edge0_valid", a_if.o_out_valid, 0);
    step();
    check("lat_edge1_valid", a_if.o_out_valid, 0);
    step();
    check("lat_edge2_word", {a_if.o_out_valid, a_if.o_out_first, a_if.o_out_last,
          a_if.o_out_data}, {3'b110, 8'h10});
    for (int i = 1; i < 4; i++) begin
      step();
      check("burst_word", {a_if.o_out_valid, a_if.o_out_first, a_if.o_out_last,
            a_if.o_out_data}, {1'b1, 1'b0, i == 3, 8'(8'h10 + i)});
    end
    drain(0);

    // Partial frame waits through an idle gap.
    for (int i = 0; i < 3; i++) feed_a(8'(8'h20 + i));
    for (int i = 0; i < 10; i++) begin
      step();
      check("partial_no_output", a_if.o_out_valid, 0);
    end
    push_frame(0, 8'h20);
    feed_a(8'h23);
    drain(0);
    check("a_no_overflow", a_if.o_overflow, 0);

    // Overflow table with downstream stalled.
    a_if.i_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      feed_a(tbl[i].data);
      check("tbl_overflow", a_if.o_overflow, tbl[i].exp_ov);
      check("tbl_dropped", a_if.o_frames_dropped, tbl[i].exp_drop);
    end
    push_frame(0, 8'h30);
    push_frame(0, 8'h34);
    a_if.i_out_ready = 1'b1;
    drain(0);
    push_frame(0, 8'h40);
    for (int i = 0; i < 4; i++) feed_a(8'(8'h40 + i));
    drain(0);
    check("a_dropped_after_recover", a_if.o_frames_dropped, 2);

    // Instance B: overflow on a frame's last word stays in accept; counter saturates.
    b_if.i_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed_b(8'(8'h50 + i));
      check("b_fill_overflow", b_if.o_overflow, 0);
    end
    feed_b(8'h58);
    check("b_ov_after_58", {b_if.o_overflow, b_if.o_frames_dropped}, {1'b1, 2'd1});
    for (int i = 0; i < 9; i++) begin
      feed_b(8'(8'h70 + i));
      check("b_saturating_drop", b_if.o_frames_dropped,
            (i < 2) ? 2'd1 : ((i < 5) ? 2'd2 : 2'd3));
    end
    push_frame(1, 8'h50);
    push_frame(1, 8'h53);
    b_if.i_out_ready = 1'b1;
    drain(1);
    push_frame(1, 8'h60);
    for (int i = 0; i < 3; i++) feed_b(8'(8'h60 + i));
    drain(1);

    // Randomized frames, gaps and ready; feeding is gated on free space.
    rand_ready = 1'b1;
    fed = 0;
    xa0 = xfer_a;
    for (int f = 0; f < 20; f++) begin
      n = 0;
      while (n < 300 && (fed - (xfer_a - xa0) + 4 > 8)) begin
        step();
        n++;
      end
      check("rand_space_timeout", n < 300, 1);
      for (int i = 0; i < 4; i++) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        d = 8'($urandom_range(0, 255));
        exp_a_q.push_back({i == 0, i == 3, d});
        feed_a(d);
        fed++;
      end
    end
    rand_ready = 1'b0;
    a_if.i_out_ready = 1'b1;
    drain(0);
    check("rand_no_new_drops", a_if.o_frames_dropped, 2);

    // Reset in the middle of a frame, then one clean frame.
    feed_a(8'h90);
    feed_a(8'h91);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("a_post_reset_status", {a_if.o_overflow, a_if.o_frames_dropped, a_if.o_out_valid}, 0);
    push_frame(0, 8'hA0);
    for (int i = 0; i < 4; i++) feed_a(8'(8'hA0 + i));
    drain(0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("a_after_reset_frame_idle", a_if.o_out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
